// File: rtl/rst_pkg.sv
// Shared types and constants for the reset-request controller: FSM state
// encoding and reset-cause bit positions.
package rst_pkg;

  localparam int CAUSE_W    = 4;
  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_NDM  = 1;
  localparam int CAUSE_SW   = 2;
  localparam int CAUSE_WDOG = 3;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } rst_state_e;

endpackage

// File: rtl/rst_req_ctrl.sv
// Reset-request controller: merges POR, ndmreset, software and watchdog requests
// into one stretched active-low request. Optional episode counter: RST_REQ_CTRL_CNT_EN.
module rst_req_ctrl
  import rst_pkg::*;
#(
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ndmreset_req_i,
  input  logic               sw_rst_req_i,
  input  logic               wdog_rst_req_i,
  input  logic               rst_cause_clr_i,
  output logic               rst_req_no,
  output logic               ndmreset_ack_o,
  output logic [CAUSE_W-1:0] rst_cause_o,
  output logic               busy_o
`ifdef RST_REQ_CTRL_CNT_EN
  ,
  output logic [7:0]         rst_count_o
`endif
);

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST    = CNT_W'(SYNC_STAGES - 1);

  rst_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               ndm_q;
  logic               ep_ndm_q, ep_ndm_d;
  logic               ndm_rise, trig, episode_done;

  assign ndm_rise     = ndmreset_req_i & ~ndm_q;
  assign trig         = ndm_rise | sw_rst_req_i | wdog_rst_req_i;
  assign episode_done = (state_q == RELEASE) && (state_d == IDLE);

  // NOTE: every variable assigned in always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = ASSERT;
          cnt_d   = '0;
        end
      end
      ASSERT: begin
        if (trig) begin
          cnt_d = '0;
        end else if (cnt_q == STRETCH_LAST) begin
          state_d = ndmreset_req_i ? HOLD : RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // sw/wdog pulses while held only touch the cause register.
      HOLD: begin
        if (!ndmreset_req_i) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (trig) begin
          state_d = ASSERT;
          cnt_d   = '0;
        end else if (cnt_q == SYNC_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear applies only in IDLE; a same-cycle request still sets its own bit.
  always_comb begin
    cause_d = cause_q;
    if ((state_q == IDLE) && rst_cause_clr_i) cause_d = '0;
    if (ndm_rise)       cause_d[CAUSE_NDM]  = 1'b1;
    if (sw_rst_req_i)   cause_d[CAUSE_SW]   = 1'b1;
    if (wdog_rst_req_i) cause_d[CAUSE_WDOG] = 1'b1;
  end

  always_comb begin
    ep_ndm_d = ep_ndm_q;
    if ((state_d == IDLE) && (state_q != IDLE)) ep_ndm_d = 1'b0;
    if (ndm_rise) ep_ndm_d = 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so all of them update from
  // the same pre-edge values; they are reset only by rst_ni, never by the
  // request this block drives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ASSERT;
      cnt_q          <= '0;
      cause_q        <= CAUSE_W'(1) << CAUSE_POR;
      ndm_q          <= 1'b0;
      ep_ndm_q       <= 1'b0;
      rst_req_no     <= 1'b0;
      ndmreset_ack_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cause_q        <= cause_d;
      ndm_q          <= ndmreset_req_i;
      ep_ndm_q       <= ep_ndm_d;
      rst_req_no     <= (state_d == IDLE) || (state_d == RELEASE);
      ndmreset_ack_o <= episode_done & ep_ndm_q;
    end
  end

  assign rst_cause_o = cause_q;
  assign busy_o      = (state_q != IDLE);

`ifdef RST_REQ_CTRL_CNT_EN
  logic [7:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (episode_done && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign rst_count_o = count_q;
`endif

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Directed self-checking bench for rst_req_ctrl (default STRETCH_CYCLES=16,
// SYNC_STAGES=2); the episode counter is exercised when RST_REQ_CTRL_CNT_EN is set.
module tb_rst_req_ctrl;

  logic       clk_i;
  logic       rst_ni;
  logic       ndmreset_req_i;
  logic       sw_rst_req_i;
  logic       wdog_rst_req_i;
  logic       rst_cause_clr_i;
  logic       rst_req_no;
  logic       ndmreset_ack_o;
  logic [3:0] rst_cause_o;
  logic       busy_o;
`ifdef RST_REQ_CTRL_CNT_EN
  logic [7:0] rst_count_o;
`endif

  int checks = 0;
  int errors = 0;

  rst_req_ctrl dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .ndmreset_req_i  (ndmreset_req_i),
    .sw_rst_req_i    (sw_rst_req_i),
    .wdog_rst_req_i  (wdog_rst_req_i),
    .rst_cause_clr_i (rst_cause_clr_i),
    .rst_req_no      (rst_req_no),
    .ndmreset_ack_o  (ndmreset_ack_o),
    .rst_cause_o     (rst_cause_o),
    .busy_o          (busy_o)
`ifdef RST_REQ_CTRL_CNT_EN
    ,
    .rst_count_o     (rst_count_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Remaining 15 low cycles of a stretch (after the trigger edge), then the rise.
  task automatic stretch_tail(input string tag);
    for (int i = 0; i < 15; i++) begin
      tick();
      check({tag, "_low"}, 32'(rst_req_no), 32'd0);
      check({tag, "_noack"}, 32'(ndmreset_ack_o), 32'd0);
    end
    tick();
    check({tag, "_rise"}, 32'(rst_req_no), 32'd1);
  endtask

  initial begin
    rst_ni          = 1'b0;
    ndmreset_req_i  = 1'b0;
    sw_rst_req_i    = 1'b0;
    wdog_rst_req_i  = 1'b0;
    rst_cause_clr_i = 1'b0;

    repeat (3) tick();
    check("rst_req", 32'(rst_req_no), 32'd0);
    check("rst_ack", 32'(ndmreset_ack_o), 32'd0);
    check("rst_cause", 32'(rst_cause_o), 32'h1);
    check("rst_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b1;

    // Power-on stretch: 16 low cycles after release, idle 2 cycles after the rise.
    for (int i = 0; i < 15; i++) begin
      tick();
      check("por_low", 32'(rst_req_no), 32'd0);
    end
    tick();
    check("por_rise", 32'(rst_req_no), 32'd1);
    check("por_busy_rel0", 32'(busy_o), 32'd1);
    tick();
    check("por_busy_rel1", 32'(busy_o), 32'd1);
    check("por_ack1", 32'(ndmreset_ack_o), 32'd0);
    tick();
    check("por_idle", 32'(busy_o), 32'd0);
    check("por_ack2", 32'(ndmreset_ack_o), 32'd0);
    check("por_cause", 32'(rst_cause_o), 32'h1);
    tick();
    check("por_stay_idle", 32'(busy_o), 32'd0);
    check("por_ack3", 32'(ndmreset_ack_o), 32'd0);

    // Software pulse from IDLE.
    sw_rst_req_i = 1'b1;
    tick();
    sw_rst_req_i = 1'b0;
    check("sw_first_low", 32'(rst_req_no), 32'd0);
    check("sw_busy", 32'(busy_o), 32'd1);
    stretch_tail("sw");
    tick();
    check("sw_ack1", 32'(ndmreset_ack_o), 32'd0);
    tick();
    check("sw_ack2", 32'(ndmreset_ack_o), 32'd0);
    check("sw_idle", 32'(busy_o), 32'd0);
    check("sw_cause", 32'(rst_cause_o), 32'h5);

    // Clear in IDLE.
    rst_cause_clr_i = 1'b1;
    tick();
    rst_cause_clr_i = 1'b0;
    check("clr_idle", 32'(rst_cause_o), 32'h0);
    check("clr_busy", 32'(busy_o), 32'd0);

    // ndmreset held 40 cycles; a sw pulse plus clear arrive while in HOLD.
    ndmreset_req_i = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 25) begin
        sw_rst_req_i    = 1'b1;
        rst_cause_clr_i = 1'b1;
      end
      tick();
      sw_rst_req_i    = 1'b0;
      rst_cause_clr_i = 1'b0;
      check("ndm_hold_low", 32'(rst_req_no), 32'd0);
    end
    check("ndm_hold_busy", 32'(busy_o), 32'd1);
    check("ndm_hold_cause", 32'(rst_cause_o), 32'h6);
    ndmreset_req_i = 1'b0;
    tick();
    check("ndm_rise", 32'(rst_req_no), 32'd1);
    check("ndm_ack_early0", 32'(ndmreset_ack_o), 32'd0);
    tick();
    check("ndm_ack_early1", 32'(ndmreset_ack_o), 32'd0);
    tick();
    check("ndm_ack", 32'(ndmreset_ack_o), 32'd1);
    check("ndm_idle", 32'(busy_o), 32'd0);
    tick();
    check("ndm_ack_once", 32'(ndmreset_ack_o), 32'd0);

    // Watchdog bite during RELEASE returns to ASSERT for a full stretch.
    sw_rst_req_i = 1'b1;
    tick();
    sw_rst_req_i = 1'b0;
    check("rel_first_low", 32'(rst_req_no), 32'd0);
    stretch_tail("rel_sw");
    wdog_rst_req_i = 1'b1;
    tick();
    wdog_rst_req_i = 1'b0;
    check("wdog_restart", 32'(rst_req_no), 32'd0);
    check("wdog_busy", 32'(busy_o), 32'd1);
    stretch_tail("wdog");
    tick();
    check("wdog_ack1", 32'(ndmreset_ack_o), 32'd0);
    tick();
    check("wdog_ack2", 32'(ndmreset_ack_o), 32'd0);
    check("wdog_idle", 32'(busy_o), 32'd0);
    check("wdog_cause", 32'(rst_cause_o), 32'hE);

    // sw + wdog together with clear in IDLE: set wins, one episode.
    rst_cause_clr_i = 1'b1;
    sw_rst_req_i    = 1'b1;
    wdog_rst_req_i  = 1'b1;
    tick();
    rst_cause_clr_i = 1'b0;
    sw_rst_req_i    = 1'b0;
    wdog_rst_req_i  = 1'b0;
    check("sim_cause", 32'(rst_cause_o), 32'hC);
    check("sim_first_low", 32'(rst_req_no), 32'd0);
    stretch_tail("sim");
    repeat (2) tick();
    check("sim_idle", 32'(busy_o), 32'd0);
    check("sim_ack", 32'(ndmreset_ack_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sim_single", 32'(busy_o), 32'd0);
      check("sim_req_high", 32'(rst_req_no), 32'd1);
    end

    // Second sw pulse mid-ASSERT restarts the stretch.
    sw_rst_req_i = 1'b1;
    tick();
    sw_rst_req_i = 1'b0;
    repeat (7) tick();
    sw_rst_req_i = 1'b1;
    tick();
    sw_rst_req_i = 1'b0;
    check("restart_low", 32'(rst_req_no), 32'd0);
    stretch_tail("restart");
    repeat (2) tick();
    check("restart_idle", 32'(busy_o), 32'd0);

`ifdef RST_REQ_CTRL_CNT_EN
    check("cnt_six", 32'(rst_count_o), 32'd6);
    for (int ep = 0; ep < 300; ep++) begin
      sw_rst_req_i = 1'b1;
      tick();
      sw_rst_req_i = 1'b0;
      repeat (18) tick();
    end
    check("cnt_sat", 32'(rst_count_o), 32'd255);
    check("cnt_sat_idle", 32'(busy_o), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
